// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM controller: controller FSM states and
// the default sizing parameters.
package data_ram_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DEPTH      = 1024;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised storage with per-byte write enables, one write port and one
// synchronous read port whose output register only moves on a read enable.
module dmem_byte_array #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024,
   parameter int IDX_W      = 10
) (
   input  logic                    clk,
   input  logic [DATA_WIDTH/8-1:0] i_wbe,
   input  logic [IDX_W-1:0]        i_waddr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic                    i_re,
   input  logic [IDX_W-1:0]        i_raddr,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Holding the read register between reads keeps the response data stable.
   always_ff @(posedge clk) begin
      for (int k = 0; k < BE_W; k++) begin
         if (i_wbe[k]) begin
            r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: byte-masked single-port request interface with a
// one-cycle response, plus a hardware sweep that zeroes the whole memory.
module data_ram_ctrl
   import data_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   input  logic                    clr_start,
   output logic                    busy
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_cnt;
   logic             r_rspValid;
   logic             r_rspErr;
   logic             r_rdSel;

   logic                  w_accept;
   logic                  w_inRange;
   logic [IDX_W-1:0]      w_idx;
   logic [BE_W-1:0]       w_wbe;
   logic [IDX_W-1:0]      w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_re;
   logic [DATA_WIDTH-1:0] w_rdData;

   // Range check uses the full address so aliases above DEPTH are rejected.
   assign w_inRange = ({1'b0, req_addr} < DEPTH_EXT);
   assign w_idx     = req_addr[IDX_W-1:0];
   assign w_accept  = req_valid && (r_state == IDLE) && !rst;
   assign w_re      = w_accept && !req_we && w_inRange;

   always_comb begin
      w_wbe   = '0;
      w_waddr = w_idx;
      w_wdata = req_wdata;
      if (!rst && r_state == CLEAR) begin
         w_wbe   = '1;
         w_waddr = r_cnt;
         w_wdata = '0;
      end else if (w_accept && req_we && w_inRange) begin
         w_wbe = req_be;
      end
   end

   dmem_byte_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk     (clk),
      .i_wbe   (w_wbe),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (w_idx),
      .o_rdata (w_rdData)
   );

   // A request accepted alongside clr_start completes first; the sweep that
   // starts on the same edge then overwrites it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= CLEAR;
         r_cnt      <= '0;
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rdSel    <= 1'b0;
      end else begin
         r_rspValid <= w_accept;
         if (w_accept) begin
            r_rspErr <= !w_inRange;
            r_rdSel  <= !req_we && w_inRange;
         end
         case (r_state)
            CLEAR: begin
               r_cnt <= r_cnt + IDX_W'(1);
               if (r_cnt == LAST_IDX) begin
                  r_state <= IDLE;
               end
            end
            IDLE: begin
               if (clr_start) begin
                  r_cnt   <= '0;
                  r_state <= CLEAR;
               end
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   assign busy      = (r_state == CLEAR);
   assign req_ready = (r_state == IDLE);
   assign rsp_valid = r_rspValid;
   assign rsp_err   = r_rspErr;
   assign rsp_rdata = r_rdSel ? w_rdData : '0;

endmodule
